// File: rtl/cpu_axil_master.sv
// Bridge from the CPU native memory port to an AXI-Lite master.
// Each CPU request becomes one AXI-Lite write or read; error responses are counted.
module cpu_axil_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [STRB_WIDTH-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_error,
    output logic [7:0]            err_count,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,

    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,

    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,

    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                state_q,     state_d;
    logic                  awvalid_q,   awvalid_d;
    logic                  wvalid_q,    wvalid_d;
    logic                  arvalid_q,   arvalid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,    awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
    logic [ADDR_WIDTH-1:0] araddr_q,    araddr_d;
    logic [2:0]            arprot_q,    arprot_d;
    logic                  mem_ready_q, mem_ready_d;
    logic                  mem_error_q, mem_error_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic [7:0]            err_count_q, err_count_d;

    // Next-state and next-output computation for the request FSM
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        araddr_d    = araddr_q;
        arprot_d    = arprot_q;
        mem_ready_d = 1'b0;
        mem_error_d = 1'b0;
        mem_rdata_d = {DATA_WIDTH{1'b0}};
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    if (mem_wstrb != {STRB_WIDTH{1'b0}}) begin
                        awaddr_d  = mem_addr;
                        wdata_d   = mem_wdata;
                        wstrb_d   = mem_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = mem_addr;
                        arprot_d  = mem_instr ? 3'b100 : 3'b000;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            // AW and W retire independently; leave once both have handshaken
            WR_REQ: begin
                awvalid_d = awvalid_q & ~m_axil_awready;
                wvalid_d  = wvalid_q & ~m_axil_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = WR_RESP;
                end else begin
                    state_d = WR_REQ;
                end
            end

            WR_RESP: begin
                if (m_axil_bvalid) begin
                    mem_ready_d = 1'b1;
                    mem_error_d = m_axil_bresp[1];
                    state_d     = DONE;
                end else begin
                    state_d = WR_RESP;
                end
            end

            RD_REQ: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_RESP;
                end else begin
                    state_d = RD_REQ;
                end
            end

            RD_RESP: begin
                if (m_axil_rvalid) begin
                    mem_ready_d = 1'b1;
                    mem_error_d = m_axil_rresp[1];
                    mem_rdata_d = m_axil_rdata;
                    state_d     = DONE;
                end else begin
                    state_d = RD_RESP;
                end
            end

            DONE: begin
                if (mem_error_q && (err_count_q != 8'hFF)) begin
                    err_count_d = err_count_q + 8'd1;
                end else begin
                    err_count_d = err_count_q;
                end
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            awaddr_q    <= {ADDR_WIDTH{1'b0}};
            wdata_q     <= {DATA_WIDTH{1'b0}};
            wstrb_q     <= {STRB_WIDTH{1'b0}};
            araddr_q    <= {ADDR_WIDTH{1'b0}};
            arprot_q    <= 3'b000;
            mem_ready_q <= 1'b0;
            mem_error_q <= 1'b0;
            mem_rdata_q <= {DATA_WIDTH{1'b0}};
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            araddr_q    <= araddr_d;
            arprot_q    <= arprot_d;
            mem_ready_q <= mem_ready_d;
            mem_error_q <= mem_error_d;
            mem_rdata_q <= mem_rdata_d;
            err_count_q <= err_count_d;
        end
    end

    assign mem_rdata      = mem_rdata_q;
    assign mem_ready      = mem_ready_q;
    assign mem_error      = mem_error_q;
    assign err_count      = err_count_q;

    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = arprot_q;
    assign m_axil_arvalid = arvalid_q;

    // Response-channel readies are pure state decodes
    assign m_axil_bready  = (state_q == WR_RESP);
    assign m_axil_rready  = (state_q == RD_RESP);

endmodule
